btb_set_assoc: RTL and testbench

Parametrised set-associative branch target buffer, the RTL successor to the direct-mapped BTB model used by the branch-predictor bench. It is indexed by fetch-stage PC and returns a predicted target. It trains from execute-stage resolved branches. Over the direct-mapped form it adds full tag compare, per-entry valid bits, N-way associativity with round-robin replacement per set, and a hit/way indication.

---
 rtl/btb_set_assoc.sv | 93 +++++++++
 tb/tb_btb_set_assoc.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/btb_set_assoc.sv
// btb_set_assoc: set-associative branch target buffer with round-robin replacement per set
module btb_set_assoc #(
    parameter int ENTRIES = 128,
    parameter int WAYS = 2,
    parameter int XLEN = 32,
    localparam int WB = WAYS > 1 ? $clog2(WAYS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            is_branch_if,
    input  logic [XLEN-1:0] pc_if,
    output logic            hit,
    output logic [WB-1:0]   hit_way,
    output logic [XLEN-1:0] predicted_pc,
    input  logic            is_branch_ex,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [XLEN-1:0] branch_pc_ex
);
    localparam int SETS = ENTRIES / WAYS;
    localparam int IB = $clog2(SETS);
    localparam int IW = IB > 0 ? IB : 1;
    localparam int TW = XLEN - IB - 2;

    logic [WAYS-1:0] valid_q [SETS];
    logic [WB-1:0]   rr_q    [SETS];
    logic [TW-1:0]   tag_q   [SETS][WAYS];
    logic [XLEN-1:0] tgt_q   [SETS][WAYS];

    logic [IW-1:0] if_idx, ex_idx;
    logic [TW-1:0] if_tag, ex_tag;
    logic          ex_hit, inv_found;
    logic [WB-1:0] ex_way, inv_way, victim, rr_next;

    // a single-set buffer has no index bits, so the index collapses to 0
    assign if_idx = IB == 0 ? '0 : IW'(pc_if >> 2);
    assign ex_idx = IB == 0 ? '0 : IW'(pc_ex >> 2);
    assign if_tag = TW'(pc_if >> (IB + 2));
    assign ex_tag = TW'(pc_ex >> (IB + 2));

    // scanning from the top way down lets the lowest matching way win
    always_comb begin
        hit = 1'b0;
        hit_way = '0;
        predicted_pc = pc_if + XLEN'(4);
        for (int w = WAYS - 1; w >= 0; w--)
            if (is_branch_if && valid_q[if_idx][w] && tag_q[if_idx][w] == if_tag) begin
                hit = 1'b1;
                hit_way = WB'(w);
                predicted_pc = tgt_q[if_idx][w];
            end
    end

    always_comb begin
        ex_hit = 1'b0;
        ex_way = '0;
        inv_found = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[ex_idx][w] && tag_q[ex_idx][w] == ex_tag) begin
                ex_hit = 1'b1;
                ex_way = WB'(w);
            end
            if (!valid_q[ex_idx][w]) begin
                inv_found = 1'b1;
                inv_way = WB'(w);
            end
        end
    end

    assign victim  = ex_hit ? ex_way : inv_found ? inv_way : rr_q[ex_idx];
    assign rr_next = rr_q[ex_idx] == WB'(WAYS - 1) ? '0 : rr_q[ex_idx] + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s] <= '0;
            end
        end else if (is_branch_ex) begin
            valid_q[ex_idx][victim] <= 1'b1;
            if (!ex_hit && !inv_found)
                rr_q[ex_idx] <= rr_next;
        end
    end

    // tags and targets are qualified by valid, so they are left out of reset
    always_ff @(posedge clk) begin
        if (!rst && is_branch_ex) begin
            tag_q[ex_idx][victim] <= ex_tag;
            tgt_q[ex_idx][victim] <= branch_pc_ex;
        end
    end
endmodule

// File: tb/tb_btb_set_assoc.sv
// tb_btb_set_assoc: drives 1-, 2- and 4-way buffers (all 64 sets) with shared stimulus
module tb_btb_set_assoc;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        is_branch_if = 1'b0;
    logic [31:0] pc_if = '0;
    logic        is_branch_ex = 1'b0;
    logic [31:0] pc_ex = '0;
    logic [31:0] branch_pc_ex = '0;

    logic        hit1, hit2, hit4;
    logic [0:0]  hw1, hw2;
    logic [1:0]  hw4;
    logic [31:0] pp1, pp2, pp4;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int          cfg;
        string       tag;
        logic [63:0] exp;
    } sb_t;
    sb_t q[$];

    always #5 clk = ~clk;

    btb_set_assoc #(.ENTRIES(64), .WAYS(1), .XLEN(32)) dut1 (
        .clk(clk), .rst(rst), .is_branch_if(is_branch_if), .pc_if(pc_if),
        .hit(hit1), .hit_way(hw1), .predicted_pc(pp1),
        .is_branch_ex(is_branch_ex), .pc_ex(pc_ex), .branch_pc_ex(branch_pc_ex));

    btb_set_assoc #(.ENTRIES(128), .WAYS(2), .XLEN(32)) dut2 (
        .clk(clk), .rst(rst), .is_branch_if(is_branch_if), .pc_if(pc_if),
        .hit(hit2), .hit_way(hw2), .predicted_pc(pp2),
        .is_branch_ex(is_branch_ex), .pc_ex(pc_ex), .branch_pc_ex(branch_pc_ex));

    btb_set_assoc #(.ENTRIES(256), .WAYS(4), .XLEN(32)) dut4 (
        .clk(clk), .rst(rst), .is_branch_if(is_branch_if), .pc_if(pc_if),
        .hit(hit4), .hit_way(hw4), .predicted_pc(pp4),
        .is_branch_ex(is_branch_ex), .pc_ex(pc_ex), .branch_pc_ex(branch_pc_ex));

    task automatic step(input logic r, input logic lk, input logic [31:0] pif,
                        input logic up, input logic [31:0] pex, input logic [31:0] tex);
        @(posedge clk);
        #1;
        rst = r;
        is_branch_if = lk;
        pc_if = pif;
        is_branch_ex = up;
        pc_ex = pex;
        branch_pc_ex = tex;
    endtask

    function automatic logic [63:0] pack(input logic h, input int w, input logic [31:0] p);
        return {h, 31'(w), p};
    endfunction

    task automatic exp3(input string tag,
                        input logic h1, input int w1, input logic [31:0] p1,
                        input logic h2, input int w2, input logic [31:0] p2,
                        input logic h4, input int w4, input logic [31:0] p4);
        q.push_back('{1, {tag, "/w1"}, pack(h1, w1, p1)});
        q.push_back('{2, {tag, "/w2"}, pack(h2, w2, p2)});
        q.push_back('{4, {tag, "/w4"}, pack(h4, w4, p4)});
    endtask

    task automatic miss3(input string tag, input logic [31:0] p);
        exp3(tag, 1'b0, 0, p, 1'b0, 0, p, 1'b0, 0, p);
    endtask

    task automatic check();
        sb_t e;
        logic [63:0] obs;
        @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            obs = e.cfg == 1 ? pack(hit1, int'(hw1), pp1) :
                  e.cfg == 2 ? pack(hit2, int'(hw2), pp2) : pack(hit4, int'(hw4), pp4);
            tests++;
            assert (obs === e.exp) else begin
                fails++;
                $error("FAIL %s: got hit=%0b way=%0d pc=%h, expected hit=%0b way=%0d pc=%h",
                       e.tag, obs[63], obs[62:32], obs[31:0], e.exp[63], e.exp[62:32], e.exp[31:0]);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        // after reset everything misses
        step(0, 1, 32'h0000_0104, 0, 0, 0);
        miss3("reset_miss", 32'h0000_0108);
        check();
        step(0, 0, 32'h100, 1, 32'h100, 32'h4000);
        miss3("idle_lookup", 32'h104);
        check();
        step(0, 1, 32'h100, 0, 0, 0);
        exp3("first_hit", 1, 0, 32'h4000, 1, 0, 32'h4000, 1, 0, 32'h4000);
        check();
        step(0, 0, 32'h100, 0, 0, 0);
        miss3("no_request", 32'h104);
        check();
        step(0, 1, 32'h10100, 0, 0, 0);
        miss3("tag_mismatch", 32'h10104);
        check();
        // fill set 0 until it evicts
        step(0, 1, 32'h200, 1, 32'h200, 32'h5000);
        miss3("pre_ins_200", 32'h204);
        check();
        step(0, 1, 32'h100, 1, 32'h300, 32'h6000);
        exp3("pre_ins_300", 0, 0, 32'h104, 1, 0, 32'h4000, 1, 0, 32'h4000);
        check();
        step(0, 1, 32'h100, 0, 0, 0);
        exp3("evicted_100", 0, 0, 32'h104, 0, 0, 32'h104, 1, 0, 32'h4000);
        check();
        step(0, 1, 32'h200, 0, 0, 0);
        exp3("kept_200", 0, 0, 32'h204, 1, 1, 32'h5000, 1, 1, 32'h5000);
        check();
        step(0, 1, 32'h300, 0, 0, 0);
        exp3("new_300", 1, 0, 32'h6000, 1, 0, 32'h6000, 1, 2, 32'h6000);
        check();
        step(0, 1, 32'h400, 1, 32'h400, 32'h7000);
        miss3("pre_ins_400", 32'h404);
        check();
        step(0, 1, 32'h200, 0, 0, 0);
        exp3("evicted_200", 0, 0, 32'h204, 0, 0, 32'h204, 1, 1, 32'h5000);
        check();
        step(0, 1, 32'h400, 0, 0, 0);
        exp3("new_400", 1, 0, 32'h7000, 1, 1, 32'h7000, 1, 3, 32'h7000);
        check();
        // overwrite a resident tag, then confirm the victim pointer did not move
        step(0, 1, 32'h300, 1, 32'h300, 32'h8000);
        exp3("pre_overwrite", 0, 0, 32'h304, 1, 0, 32'h6000, 1, 2, 32'h6000);
        check();
        step(0, 1, 32'h300, 0, 0, 0);
        exp3("overwrite", 1, 0, 32'h8000, 1, 0, 32'h8000, 1, 2, 32'h8000);
        check();
        step(0, 1, 32'h400, 1, 32'h500, 32'hA000);
        exp3("pre_ins_500", 0, 0, 32'h404, 1, 1, 32'h7000, 1, 3, 32'h7000);
        check();
        step(0, 1, 32'h500, 0, 0, 0);
        exp3("victim_500", 1, 0, 32'hA000, 1, 0, 32'hA000, 1, 0, 32'hA000);
        check();
        step(0, 1, 32'h400, 0, 0, 0);
        exp3("after_500_400", 0, 0, 32'h404, 1, 1, 32'h7000, 1, 3, 32'h7000);
        check();
        step(0, 1, 32'h300, 0, 0, 0);
        exp3("after_500_300", 0, 0, 32'h304, 0, 0, 32'h304, 1, 2, 32'h8000);
        check();
        // same-cycle lookup and update: no bypass
        step(0, 1, 32'h180, 1, 32'h180, 32'h9000);
        miss3("simul_same", 32'h184);
        check();
        step(0, 1, 32'h180, 0, 0, 0);
        exp3("simul_next", 1, 0, 32'h9000, 1, 0, 32'h9000, 1, 0, 32'h9000);
        check();
        // reset while an update is presented discards everything
        step(1, 0, 0, 1, 32'h500, 32'hB000);
        step(0, 1, 32'h500, 0, 0, 0);
        miss3("rst_500", 32'h504);
        check();
        step(0, 1, 32'h180, 0, 0, 0);
        miss3("rst_180", 32'h184);
        check();
        step(0, 1, 32'h400, 0, 0, 0);
        miss3("rst_400", 32'h404);
        check();
        step(0, 1, 32'hFFFF_FFFC, 1, 32'h700, 32'hC000);
        miss3("wrap", 32'h0000_0000);
        check();
        step(0, 1, 32'h700, 0, 0, 0);
        exp3("post_rst_ins", 1, 0, 32'hC000, 1, 0, 32'hC000, 1, 0, 32'hC000);
        check();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
